fp_issue_unit: RTL and testbench

FP_ISSUE_UNIT -- requirements
Module: fp_issue_unit

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_regfile.sv | 42 ++++
 rtl/fp_issue_unit.sv | 127 ++++++++++++
 tb/tb_fp_issue_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP issue unit: op codes, FSM state type, default register count.
package fp_pkg;

  localparam int FP_NREG_DEFAULT = 16;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_MUL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } fp_state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == FP_ADD) || (op == FP_MUL);
  endfunction

endpackage

// File: rtl/fp_regfile.sv
// NREG x 32 register file: two operand read ports, one debug read port, writeback and external
// write ports sharing one cycle; on an address collision the writeback wins.
module fp_regfile #(
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ra_addr,
  output logic [31:0]   ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [31:0]   rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          ext_en,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_data
);

  logic [31:0] mem_q [NREG];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i)))
          mem_q[i] <= wb_data;
        else if (ext_en && (ext_addr == AW'(i)))
          mem_q[i] <= ext_data;
      end
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/fp_issue_unit.sv
// Issues one add/mul at a time to an external combinational FPU, waits FPU_LAT cycles, writes the
// result back and pulses done_valid; illegal ops take a one-cycle ERR detour with no side effects.
module fp_issue_unit
  import fp_pkg::*;
#(
  parameter int NREG    = FP_NREG_DEFAULT,
  parameter int FPU_LAT = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [31:0]   fp_a,
  output logic [31:0]   fp_b,
  output logic [1:0]    fp_control,
  input  logic [31:0]   fp_result,
  output logic          done_valid,
  output logic [AW-1:0] done_rd,
  output logic [31:0]   done_data,
  output logic          err_valid,
  output logic          busy
);

  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  fp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] rd_q;
  logic [31:0]   fp_a_q, fp_b_q, done_data_q;
  logic [1:0]    fp_ctl_q;
  logic [AW-1:0] done_rd_q;
  logic          done_valid_q;

  logic          accept, accept_legal, capture;
  logic [31:0]   ra_data, rb_data, op_a, op_b;

  fp_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra_addr  (req_rn),
    .ra_data  (ra_data),
    .rb_addr  (req_rm),
    .rb_data  (rb_data),
    .dbg_addr (rd_addr),
    .dbg_data (rd_data),
    .wb_en    (capture),
    .wb_addr  (rd_q),
    .wb_data  (fp_result),
    .ext_en   (wr_en),
    .ext_addr (wr_addr),
    .ext_data (wr_data)
  );

  // A same-edge external load of a source register is forwarded into the operand.
  assign op_a = (wr_en && (wr_addr == req_rn)) ? wr_data : ra_data;
  assign op_b = (wr_en && (wr_addr == req_rm)) ? wr_data : rb_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = op_is_legal(req_op) ? ST_WAIT : ST_ERR;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    err_valid    = (state_q == ST_ERR);
    capture      = (state_q == ST_WAIT) && (cnt_q == '0);
    accept       = req_valid && req_ready;
    accept_legal = accept && op_is_legal(req_op);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      rd_q         <= '0;
      fp_a_q       <= '0;
      fp_b_q       <= '0;
      fp_ctl_q     <= FP_ADD;
      done_valid_q <= 1'b0;
      done_rd_q    <= '0;
      done_data_q  <= '0;
    end else begin
      done_valid_q <= capture;
      if (accept_legal) begin
        fp_a_q   <= op_a;
        fp_b_q   <= op_b;
        fp_ctl_q <= req_op;
        rd_q     <= req_rd;
        cnt_q    <= CW'(FPU_LAT - 1);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (capture) begin
        done_data_q <= fp_result;
        done_rd_q   <= rd_q;
      end
    end
  end

  assign fp_a       = fp_a_q;
  assign fp_b       = fp_b_q;
  assign fp_control = fp_ctl_q;
  assign done_valid = done_valid_q;
  assign done_rd    = done_rd_q;
  assign done_data  = done_data_q;

endmodule

// File: tb/tb_fp_issue_unit.sv
// Directed bench for fp_issue_unit: one instance with FPU_LAT=1, one with FPU_LAT=3, each driven
// by a table-based FPU model that knows the exact IEEE results of the vectors used here.
module tb_fp_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Known single-precision results; anything else returns a distinct non-FP pattern.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (op == 2'b00 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
    if (op == 2'b01 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40580000;
    if (op == 2'b00 && a == 32'h40000000 && b == 32'h40100000) return 32'h40880000;
    if (op == 2'b00 && a == 32'h40700000 && b == 32'h40100000) return 32'h40C00000;
    return a + b + {30'd0, op};
  endfunction

  // ---------------- instance 0: FPU_LAT = 1 ----------------
  logic        rst0_n, rv0, rr0, wen0, dv0, ev0, busy0;
  logic [1:0]  op0, ctl0;
  logic [3:0]  rd0, rn0, rm0, waddr0, raddr0, drd0;
  logic [31:0] wdat0, rdat0, a0, b0, res0, dd0;
  assign res0 = fpu_model(a0, b0, ctl0);

  fp_issue_unit #(.NREG(16), .FPU_LAT(1)) u0 (
    .clk(clk), .reset_n(rst0_n), .req_valid(rv0), .req_ready(rr0), .req_op(op0),
    .req_rd(rd0), .req_rn(rn0), .req_rm(rm0), .wr_en(wen0), .wr_addr(waddr0), .wr_data(wdat0),
    .rd_addr(raddr0), .rd_data(rdat0), .fp_a(a0), .fp_b(b0), .fp_control(ctl0),
    .fp_result(res0), .done_valid(dv0), .done_rd(drd0), .done_data(dd0),
    .err_valid(ev0), .busy(busy0)
  );

  // ---------------- instance 3: FPU_LAT = 3 ----------------
  logic        rst3_n, rv3, rr3, wen3, dv3, ev3, busy3;
  logic [1:0]  op3, ctl3;
  logic [3:0]  rd3, rn3, rm3, waddr3, raddr3, drd3;
  logic [31:0] wdat3, rdat3, a3, b3, res3, dd3;
  assign res3 = fpu_model(a3, b3, ctl3);

  fp_issue_unit #(.NREG(16), .FPU_LAT(3)) u3 (
    .clk(clk), .reset_n(rst3_n), .req_valid(rv3), .req_ready(rr3), .req_op(op3),
    .req_rd(rd3), .req_rn(rn3), .req_rm(rm3), .wr_en(wen3), .wr_addr(waddr3), .wr_data(wdat3),
    .rd_addr(raddr3), .rd_data(rdat3), .fp_a(a3), .fp_b(b3), .fp_control(ctl3),
    .fp_result(res3), .done_valid(dv3), .done_rd(drd3), .done_data(dd3),
    .err_valid(ev3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic [1:0] op, input logic [3:0] d, input logic [3:0] n,
                      input logic [3:0] m);
    rv0 = 1'b1; op0 = op; rd0 = d; rn0 = n; rm0 = m;
  endtask

  task automatic rdchk0(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    raddr0 = addr;
    #1;
    chk(tag, rdat0, exp);
  endtask

  int          acc_cyc[$];
  logic [31:0] done_q[$];
  logic        acc;
  int          nreq;

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rv0 = 0; op0 = 0; rd0 = 0; rn0 = 0; rm0 = 0;
    wen0 = 0; waddr0 = 0; wdat0 = 0; raddr0 = 0;
    rst3_n = 1'b0; rv3 = 0; op3 = 0; rd3 = 0; rn3 = 0; rm3 = 0;
    wen3 = 0; waddr3 = 0; wdat3 = 0; raddr3 = 0;
    step(); step();
    chk("rst_ready", 32'(rr0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_fp_a", a0, 32'd0);
    chk("rst_fp_control", 32'(ctl0), 32'd0);
    chk("rst_done_valid", 32'(dv0), 32'd0);
    chk("rst_err_valid", 32'(ev0), 32'd0);
    chk("rst_done_data", dd0, 32'd0);
    chk("rst_reg0", rdat0, 32'd0);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // Load operands into both instances.
    wen0 = 1; waddr0 = 1; wdat0 = 32'h3FC00000;
    wen3 = 1; waddr3 = 1; wdat3 = 32'h3FC00000;
    step();
    waddr0 = 2; wdat0 = 32'h40100000;
    waddr3 = 2; wdat3 = 32'h40100000;
    step();
    wen0 = 0; wen3 = 0;
    rdchk0("load_r1", 1, 32'h3FC00000);
    rdchk0("load_r2", 2, 32'h40100000);

    // add r3,r1,r2
    req0(2'b00, 3, 1, 2);
    step();
    rv0 = 0;
    chk("add_ready_low", 32'(rr0), 32'd0);
    chk("add_busy", 32'(busy0), 32'd1);
    chk("add_fp_a", a0, 32'h3FC00000);
    chk("add_fp_b", b0, 32'h40100000);
    chk("add_no_done_yet", 32'(dv0), 32'd0);
    rdchk0("add_r3_old", 3, 32'd0);
    step();
    chk("add_done_valid", 32'(dv0), 32'd1);
    chk("add_done_data", dd0, 32'h40700000);
    chk("add_done_rd", 32'(drd0), 32'd3);
    chk("add_ready_in_done", 32'(rr0), 32'd1);
    rdchk0("add_r3_new", 3, 32'h40700000);

    // mul r4,r1,r2 issued in the done_valid cycle
    req0(2'b01, 4, 1, 2);
    step();
    rv0 = 0;
    chk("mul_done_cleared", 32'(dv0), 32'd0);
    chk("mul_ready_low", 32'(rr0), 32'd0);
    chk("mul_fp_control", 32'(ctl0), 32'd1);
    step();
    chk("mul_done_valid", 32'(dv0), 32'd1);
    chk("mul_done_data", dd0, 32'h40580000);
    rdchk0("mul_r4", 4, 32'h40580000);
    step();
    chk("mul_done_single", 32'(dv0), 32'd0);

    // illegal op 2'b10 targeting r1
    req0(2'b10, 1, 3, 4);
    step();
    rv0 = 0;
    chk("ill_err_valid", 32'(ev0), 32'd1);
    chk("ill_busy", 32'(busy0), 32'd1);
    chk("ill_fp_a_kept", a0, 32'h3FC00000);
    chk("ill_fp_control_kept", 32'(ctl0), 32'd1);
    step();
    chk("ill_err_single", 32'(ev0), 32'd0);
    chk("ill_no_done", 32'(dv0), 32'd0);
    chk("ill_ready_back", 32'(rr0), 32'd1);
    rdchk0("ill_r1_kept", 1, 32'h3FC00000);

    // add r5,r1,r2 with a same-edge load of r1
    req0(2'b00, 5, 1, 2);
    wen0 = 1; waddr0 = 1; wdat0 = 32'h40000000;
    step();
    rv0 = 0; wen0 = 0;
    chk("byp_fp_a", a0, 32'h40000000);
    chk("byp_fp_b", b0, 32'h40100000);
    step();
    chk("byp_done_data", dd0, 32'h40880000);
    rdchk0("byp_r5", 5, 32'h40880000);
    rdchk0("byp_r1", 1, 32'h40000000);

    // external write to r7 at the capture edge of add r7: writeback wins
    req0(2'b00, 7, 1, 2);
    step();
    rv0 = 0;
    wen0 = 1; waddr0 = 7; wdat0 = 32'hDEADBEEF;
    step();
    wen0 = 0;
    rdchk0("coll_r7_wb_wins", 7, 32'h40880000);

    // external write to r8 at the capture edge of add r9: both apply
    req0(2'b00, 9, 1, 2);
    step();
    rv0 = 0;
    wen0 = 1; waddr0 = 8; wdat0 = 32'h12345678;
    step();
    wen0 = 0;
    rdchk0("both_r9", 9, 32'h40880000);
    rdchk0("both_r8", 8, 32'h12345678);
    step();

    // reset pulse during WAIT of mul r6
    req0(2'b01, 6, 1, 2);
    step();
    rv0 = 0;
    #2 rst0_n = 1'b0;
    #2 rst0_n = 1'b1;
    step();
    chk("rstmid_no_done", 32'(dv0), 32'd0);
    chk("rstmid_ready", 32'(rr0), 32'd1);
    rdchk0("rstmid_r6", 6, 32'd0);
    step();
    chk("rstmid_no_done_later", 32'(dv0), 32'd0);

    // FPU_LAT=3: three back-to-back requests held valid continuously
    nreq = 0;
    rv3 = 1; op3 = 2'b00; rd3 = 3; rn3 = 1; rm3 = 2;
    for (int c = 0; c < 20; c++) begin
      acc = rv3 && rr3;
      step();
      if (acc) begin
        acc_cyc.push_back(c);
        nreq++;
        if (nreq == 1) begin op3 = 2'b01; rd3 = 4; rn3 = 1; rm3 = 2; end
        else if (nreq == 2) begin op3 = 2'b00; rd3 = 5; rn3 = 3; rm3 = 2; end
        else rv3 = 0;
      end
      if (dv3) done_q.push_back(dd3);
    end
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    chk("b2b_dones", 32'(done_q.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end
    if (done_q.size() == 3) begin
      chk("b2b_res0", done_q[0], 32'h40700000);
      chk("b2b_res1", done_q[1], 32'h40580000);
      chk("b2b_res2", done_q[2], 32'h40C00000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
